// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and nibble-to-ASCII helper for the hex
// formatter.
`timescale 1ns/1ps
package uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEX,
    ST_CR,
    ST_LF
  } fmt_state_e;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) hex_ascii = ASCII_0 + {4'h0, nib};
    else             hex_ascii = ASCII_A + {4'h0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/uart_hex_fmt_if.sv
// Word input and character output handshake of the hex formatter.
`timescale 1ns/1ps
interface uart_hex_fmt_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        tx_req;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        busy;

  modport master (
    output in_valid, in_data, tx_ready,
    input  in_ready, tx_req, tx_data, busy
  );

  modport slave (
    input  in_valid, in_data, tx_ready,
    output in_ready, tx_req, tx_data, busy
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags.
`timescale 1ns/1ps
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  // Occupancy after this cycle's push/pop; both together leave it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two. full resets to 1
  // so the write side stays closed until the first edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b1;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
endmodule

// File: rtl/uart_hex_fmt.sv
// Prints buffered 32-bit words as 8 uppercase hex characters (optionally
// followed by CR LF) through a request/acknowledge character port.
`timescale 1ns/1ps
module uart_hex_fmt
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter bit          APPEND_CRLF = 1'b1
) (
  input logic           clk,
  input logic           reset,
  uart_hex_fmt_if.slave bus
);
  fmt_state_e  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic        req_q, req_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  chr_d;
  logic [3:0]  nib_d;
  logic        take;
  logic        pop;
  logic        in_ready;
  logic [31:0] fifo_dout;
  logic        fifo_full, fifo_empty;

  assign in_ready = !fifo_full;

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (reset),
    .push_i (bus.in_valid && in_ready),
    .pop_i  (pop),
    .din_i  (bus.in_data),
    .dout_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // An acknowledge only counts while a character is actually being offered.
  assign take = bus.tx_ready && req_q;

  // Next state: load a word from the FIFO, then step through its characters.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          word_d  = fifo_dout;
          idx_d   = '0;
          state_d = ST_HEX;
        end
      end
      ST_HEX: begin
        if (take) begin
          if (idx_q != 3'd7) idx_d = idx_q + 3'd1;
          else               state_d = APPEND_CRLF ? ST_CR : ST_IDLE;
        end
      end
      ST_CR:   if (take) state_d = ST_LF;
      ST_LF:   if (take) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Nibble (7 - idx) is the MSB-first digit; ~idx equals 7 - idx on 3 bits.
  assign nib_d = word_q[{~idx_d, 2'b00} +: 4];

  // Registered character: held back one cycle after the pop, then it tracks
  // the next state so a new character appears on the edge the old one is taken.
  always_comb begin
    req_d = (state_q != ST_IDLE) && (state_d != ST_IDLE);
    case (state_d)
      ST_HEX:  chr_d = hex_ascii(nib_d);
      ST_CR:   chr_d = ASCII_CR;
      ST_LF:   chr_d = ASCII_LF;
      default: chr_d = data_q;
    endcase
    data_d = req_d ? chr_d : data_q;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      req_q   <= req_d;
      data_q  <= data_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.tx_req   = req_q;
  assign bus.tx_data  = data_q;
  assign bus.busy     = !fifo_empty || (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_hex_fmt.sv
// Bench for uart_hex_fmt: character-stream model plus directed scenarios.
`timescale 1ns/1ps
module tb_uart_hex_fmt;
  localparam int unsigned ACK_DLY  = 20;
  localparam int unsigned UART_DIV = 16;

  typedef enum int {ACK_NONE, ACK_DELAY, ACK_UART} ack_mode_e;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  uart_hex_fmt_if a_if ();
  uart_hex_fmt_if b_if ();

  uart_hex_fmt #(.FIFO_DEPTH(4), .APPEND_CRLF(1'b1)) dut_a (
    .clk(clk), .reset(rst_a), .bus(a_if));
  uart_hex_fmt #(.FIFO_DEPTH(2), .APPEND_CRLF(1'b0)) dut_b (
    .clk(clk), .reset(rst_b), .bus(b_if));

  int checks = 0;
  int failures = 0;

  ack_mode_e   ack_mode = ACK_NONE;
  int unsigned pulse_req = 0;
  int unsigned pulse_done = 0;
  logic        uline = 1'b1;

  logic [7:0] exp_q[$];
  logic [7:0] taken_q[$];
  logic [7:0] b_taken[$];
  logic [7:0] rx_q[$];

  string HEXS = "0123456789ABCDEF";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Stream model: every accepted word must appear as its characters, in order,
  // each taken exactly once; an offered character must not move until taken.
  logic       prev_req = 1'b0;
  logic       prev_took = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (rst_a) begin
      exp_q.delete();
      prev_req  = 1'b0;
      prev_took = 1'b0;
    end else begin
      if (prev_req && !prev_took) begin
        chk("hold_req", a_if.tx_req, 1);
        chk("hold_data", a_if.tx_data, prev_data);
      end
      if (a_if.tx_req && a_if.tx_ready) begin
        taken_q.push_back(a_if.tx_data);
        if (exp_q.size() == 0) fail_msg("unexpected_char");
        else chk("stream_char", a_if.tx_data, exp_q.pop_front());
      end
      if (a_if.in_valid && a_if.in_ready) begin
        for (int i = 7; i >= 0; i--) exp_q.push_back(HEXS[a_if.in_data[4*i +: 4]]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end
      prev_req  = a_if.tx_req;
      prev_data = a_if.tx_data;
      prev_took = a_if.tx_req && a_if.tx_ready;
    end
  end

  // Character consumer for instance A: fixed-delay ack, serial uart, or none.
  initial begin
    int unsigned wait_cnt = 0;
    int unsigned u_bits = 0;
    int unsigned u_div = 0;
    logic [9:0]  u_sh = '1;
    a_if.tx_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      a_if.tx_ready = 1'b0;
      if (pulse_req != pulse_done) begin
        a_if.tx_ready = 1'b1;
        pulse_done++;
      end else begin
        case (ack_mode)
          ACK_DELAY: begin
            if (a_if.tx_req) begin
              if (wait_cnt == ACK_DLY - 1) begin
                a_if.tx_ready = 1'b1;
                wait_cnt = 0;
              end else wait_cnt++;
            end else wait_cnt = 0;
          end
          ACK_UART: begin
            if (u_bits != 0) begin
              uline = u_sh[0];
              u_div++;
              if (u_div == UART_DIV) begin
                u_div = 0;
                u_sh  = u_sh >> 1;
                u_bits--;
              end
              if (u_bits == 0) uline = 1'b1;
            end else if (a_if.tx_req) begin
              u_sh   = {1'b1, a_if.tx_data, 1'b0};
              u_bits = 10;
              u_div  = 0;
              a_if.tx_ready = 1'b1;
            end
          end
          default: wait_cnt = 0;
        endcase
      end
    end
  end

  // Serial line decoder, 8N1, sampling mid-bit.
  initial begin
    logic [7:0] rb;
    rb = '0;
    forever begin
      @(negedge uline);
      repeat (UART_DIV / 2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (UART_DIV) @(posedge clk);
        rb[i] = uline;
      end
      repeat (UART_DIV) @(posedge clk);
      rx_q.push_back(rb);
    end
  end

  // Instance B consumer acks on alternate cycles; its characters are logged.
  initial begin
    b_if.tx_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      b_if.tx_ready = b_if.tx_req && !b_if.tx_ready;
    end
  end
  always @(negedge clk) begin
    if (!rst_b && b_if.tx_req && b_if.tx_ready) b_taken.push_back(b_if.tx_data);
  end

  task automatic push_a(input logic [31:0] w);
    logic acc;
    int unsigned n;
    n = 0;
    a_if.in_valid = 1'b1;
    a_if.in_data  = w;
    forever begin
      acc = a_if.in_ready;
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 3000) begin
        fail_msg("push_timeout");
        break;
      end
    end
    a_if.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int unsigned budget);
    int unsigned n;
    n = 0;
    while (a_if.busy || a_if.tx_req) begin
      @(posedge clk); #1;
      n++;
      if (n > budget) begin
        fail_msg({name, "_idle_timeout"});
        break;
      end
    end
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_taken(input int unsigned total, input int unsigned budget);
    int unsigned n;
    n = 0;
    while (taken_q.size() < total) begin
      @(posedge clk); #1;
      n++;
      if (n > budget) begin
        fail_msg("taken_timeout");
        break;
      end
    end
  endtask

  task automatic chk_seq(input string name, input int unsigned base, input logic [7:0] lit[$]);
    chk({name, "_len"}, taken_q.size() - base, lit.size());
    for (int unsigned i = 0; i < lit.size(); i++)
      if (base + i < taken_q.size()) chk(name, taken_q[base + i], lit[i]);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int unsigned base;
    int unsigned n;
    logic [7:0]  lit[$];
    logic [31:0] words[6];
    string       line_s;

    a_if.in_valid = 1'b0;
    a_if.in_data  = '0;
    b_if.in_valid = 1'b0;
    b_if.in_data  = '0;

    // Reset values and in_ready rising on the first edge after release.
    repeat (3) @(posedge clk); #1;
    chk("rst_tx_req", a_if.tx_req, 0);
    chk("rst_tx_data", a_if.tx_data, 8'h00);
    chk("rst_busy", a_if.busy, 0);
    chk("rst_in_ready", a_if.in_ready, 0);
    chk("rst_b_in_ready", b_if.in_ready, 0);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1 chk("in_ready_before_edge", a_if.in_ready, 0);
    @(posedge clk); #1;
    chk("in_ready_rise", a_if.in_ready, 1);
    chk("b_in_ready_rise", b_if.in_ready, 1);

    // DEADBEEF with latency and 20-cycle acks.
    ack_mode = ACK_DELAY;
    base = taken_q.size();
    push_a(32'hDEADBEEF);
    chk("lat_busy_n", a_if.busy, 1);
    @(posedge clk); #1;
    chk("lat_req_n1", a_if.tx_req, 0);
    @(posedge clk); #1;
    chk("lat_req_n2", a_if.tx_req, 1);
    chk("lat_first_char", a_if.tx_data, 8'h44);
    wait_idle("deadbeef", 2000);
    lit = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    chk_seq("deadbeef", base, lit);
    chk("deadbeef_busy", a_if.busy, 0);

    // Acks withheld for 1000 cycles in the middle of a word.
    base = taken_q.size();
    push_a(32'hCAFE0123);
    wait_taken(base + 3, 500);
    ack_mode = ACK_NONE;
    repeat (1000) @(posedge clk);
    #1;
    chk("stall_req", a_if.tx_req, 1);
    chk("stall_char", a_if.tx_data, 8'h45);
    ack_mode = ACK_DELAY;
    wait_idle("stall", 2000);
    lit = '{8'h43, 8'h41, 8'h46, 8'h45, 8'h30, 8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A};
    chk_seq("stall", base, lit);

    // Ack pulse while idle does nothing.
    ack_mode = ACK_NONE;
    base = taken_q.size();
    pulse_req++;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_pulse_req", a_if.tx_req, 0);
    chk("idle_pulse_busy", a_if.busy, 0);
    chk("idle_pulse_taken", taken_q.size() - base, 0);

    // Back-to-back words with no acks: five fit (one popped, four buffered).
    words = '{32'h11111111, 32'h2468ACE0, 32'hFFFFFFFF,
              32'h00000000, 32'h13579BDF, 32'h89ABCDEF};
    base = taken_q.size();
    for (int i = 0; i < 5; i++) push_a(words[i]);
    chk("burst_full_ready", a_if.in_ready, 0);
    chk("burst_busy", a_if.busy, 1);
    a_if.in_valid = 1'b1;
    a_if.in_data  = words[5];
    repeat (10) @(posedge clk);
    #1;
    chk("burst_held_off", a_if.in_ready, 0);
    chk("burst_first_char", a_if.tx_data, 8'h31);
    ack_mode = ACK_DELAY;
    push_a(words[5]);
    wait_idle("burst", 3000);
    chk("burst_chars", taken_q.size() - base, 60);

    // Reset during the 4th character with two words queued.
    base = taken_q.size();
    push_a(32'h12345678);
    push_a(32'hAAAA5555);
    push_a(32'h01020304);
    wait_taken(base + 3, 1000);
    chk("pre_reset_req", a_if.tx_req, 1);
    chk("pre_reset_char", a_if.tx_data, 8'h34);
    rst_a = 1'b1;
    #1;
    chk("mid_reset_req", a_if.tx_req, 0);
    chk("mid_reset_busy", a_if.busy, 0);
    chk("mid_reset_in_ready", a_if.in_ready, 0);
    chk("mid_reset_data", a_if.tx_data, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("post_reset_busy", a_if.busy, 0);
    chk("post_reset_req", a_if.tx_req, 0);
    base = taken_q.size();
    push_a(32'h0000000F);
    wait_idle("after_reset", 2000);
    lit = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h46, 8'h0D, 8'h0A};
    chk_seq("after_reset", base, lit);

    // Through a serial transmitter model onto the line.
    ack_mode = ACK_UART;
    base = rx_q.size();
    push_a(32'hDEADBEEF);
    n = 0;
    while (rx_q.size() < base + 10 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    line_s = "DEADBEEF\r\n";
    chk("uart_len", rx_q.size() - base, 10);
    for (int i = 0; i < 10; i++)
      if (base + i < rx_q.size()) chk("uart_rx", rx_q[base + i], line_s[i]);
    wait_idle("uart", 500);
    ack_mode = ACK_NONE;

    // Instance without CR LF.
    b_if.in_valid = 1'b1;
    b_if.in_data  = 32'h0123ABCF;
    @(posedge clk); #1;
    b_if.in_valid = 1'b0;
    n = 0;
    while ((b_if.busy || b_if.tx_req) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("nocrlf_idle", b_if.busy, 0);
    chk("nocrlf_len", b_taken.size(), 8);
    lit = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h41, 8'h42, 8'h43, 8'h46};
    for (int i = 0; i < 8; i++)
      if (i < b_taken.size()) chk("nocrlf_char", b_taken[i], lit[i]);
    repeat (5) @(posedge clk);
    #1;
    chk("nocrlf_req_low", b_if.tx_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
